// File: rtl/axis_level_trigger_pkg.sv
// Shared types for the level/edge trigger stage: FSM state encoding and slope select values.
package axis_trigger_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2
    } trig_state_t;

    localparam logic SLOPE_RISING  = 1'b0;
    localparam logic SLOPE_FALLING = 1'b1;

endpackage

// File: rtl/axis_level_trigger_if.sv
// AXI-Stream bundle used on both sides of the trigger stage; tuser is only produced on the master side.
interface axis_level_trigger_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tvalid;
    logic                    tlast;
    logic                    tuser;
    logic                    tready;

    modport master (output tdata, tstrb, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tstrb, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_level_trigger_pipe_reg.sv
// Single-stage valid/ready register for a packed payload; full throughput, holds under back-pressure.
module axis_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_payload,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_payload
);
    logic             valid_reg;
    logic [WIDTH-1:0] payload_reg;

    assign s_ready   = !valid_reg || m_ready;
    assign m_valid   = valid_reg;
    assign m_payload = payload_reg;

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            valid_reg   <= 1'b0;
            payload_reg <= '0;
        end else if (s_ready) begin
            valid_reg <= s_valid;
            if (s_valid) begin
                payload_reg <= s_payload;
            end
        end
    end
endmodule

// File: rtl/axis_level_trigger.sv
// Pass-through AXI-Stream stage that tags the beat crossing a signed level and pulses trigger on its transfer.
// Optional hysteresis arming is enabled by defining AXIS_LEVEL_TRIGGER_HYST_EN.
module axis_level_trigger
    import axis_trigger_pkg::*;
#(
    parameter int DATA_WIDTH    = 24,
    parameter int HOLDOFF_WIDTH = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     arm,
    input  logic                     slope,
    input  logic [DATA_WIDTH-1:0]    level,
    input  logic [HOLDOFF_WIDTH-1:0] holdoff,
`ifdef AXIS_LEVEL_TRIGGER_HYST_EN
    input  logic [DATA_WIDTH-1:0]    hyst,
`endif
    axis_level_trigger_if.slave      s_axis,
    axis_level_trigger_if.master     m_axis,
    output logic                     trigger,
    output logic                     armed
);
    localparam int STRB_WIDTH    = DATA_WIDTH / 8;
    localparam int PAYLOAD_WIDTH = DATA_WIDTH + STRB_WIDTH + 2;

    trig_state_t                  state_reg, state_next;
    logic [HOLDOFF_WIDTH-1:0]     cnt_reg, cnt_next;
    logic signed [DATA_WIDTH-1:0] prev_reg;
    logic                         prev_ok_reg;
    logic                         armed_reg;

    logic                         accept;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] cur;
    logic signed [DATA_WIDTH-1:0] lvl;
    logic                         crossing;
    logic                         qualified;
    logic                         fire;

    logic                         pipe_valid;
    logic [PAYLOAD_WIDTH-1:0]     pipe_payload;

    assign accept = s_axis.tvalid && in_ready;
    assign cur    = s_axis.tdata;
    assign lvl    = level;

    // Edge detection needs a valid previous sample taken while armed or in holdoff.
    assign crossing = prev_ok_reg &&
                      ((slope == SLOPE_RISING) ? (prev_reg < lvl && cur >= lvl)
                                               : (prev_reg > lvl && cur <= lvl));

`ifdef AXIS_LEVEL_TRIGGER_HYST_EN
    logic                       primed_reg;
    logic signed [DATA_WIDTH:0] cur_ext, lvl_ext, hyst_ext, lo_thr, hi_thr;

    assign cur_ext  = {cur[DATA_WIDTH-1], cur};
    assign lvl_ext  = {lvl[DATA_WIDTH-1], lvl};
    assign hyst_ext = {1'b0, hyst};
    assign lo_thr   = lvl_ext - hyst_ext;
    assign hi_thr   = lvl_ext + hyst_ext;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            primed_reg <= 1'b0;
        end else if (state_reg != ARMED && state_next == ARMED) begin
            primed_reg <= 1'b0;
        end else if (state_reg == ARMED && accept &&
                     ((slope == SLOPE_RISING) ? (cur_ext < lo_thr) : (cur_ext > hi_thr))) begin
            primed_reg <= 1'b1;
        end
    end

    assign qualified = crossing && primed_reg;
`else
    assign qualified = crossing;
`endif

    assign fire = (state_reg == ARMED) && accept && qualified;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (arm) state_next = ARMED;
            end
            ARMED: begin
                if (fire) begin
                    state_next = HOLDOFF;
                    cnt_next   = holdoff;
                end
            end
            HOLDOFF: begin
                // An exhausted count releases after one cycle even with no beat flowing.
                if (cnt_reg == '0) begin
                    state_next = ARMED;
                end else if (accept) begin
                    cnt_next = cnt_reg - HOLDOFF_WIDTH'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        if (!arm) state_next = IDLE;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            prev_reg    <= '0;
            prev_ok_reg <= 1'b0;
            armed_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            armed_reg <= (state_next == ARMED);
            if (accept) prev_reg <= cur;
            if (state_reg == IDLE) begin
                prev_ok_reg <= 1'b0;
            end else if (accept) begin
                prev_ok_reg <= 1'b1;
            end
        end
    end

    axis_pipe_reg #(
        .WIDTH (PAYLOAD_WIDTH)
    ) u_pipe (
        .clk       (aclk),
        .srst_n    (aresetn),
        .s_valid   (s_axis.tvalid),
        .s_ready   (in_ready),
        .s_payload ({fire, s_axis.tlast, s_axis.tstrb, s_axis.tdata}),
        .m_valid   (pipe_valid),
        .m_ready   (m_axis.tready),
        .m_payload (pipe_payload)
    );

    assign s_axis.tready = in_ready;
    assign m_axis.tvalid = pipe_valid;
    assign {m_axis.tuser, m_axis.tlast, m_axis.tstrb, m_axis.tdata} = pipe_payload;

    assign trigger = pipe_valid && m_axis.tready && pipe_payload[PAYLOAD_WIDTH-1];
    assign armed   = armed_reg;
endmodule

// File: tb/tb_axis_level_trigger.sv
// Scoreboard bench for axis_level_trigger: directed beats push expected outputs, a monitor pops on transfer.
module tb_axis_level_trigger;
    import axis_trigger_pkg::*;

    localparam int DW = 24;
    localparam int HW = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic [2:0]    strb;
        logic          last;
        logic          user;
    } exp_t;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          arm;
    logic          slope;
    logic [DW-1:0] level;
    logic [HW-1:0] holdoff;
    logic          trigger;
    logic          armed;
`ifdef AXIS_LEVEL_TRIGGER_HYST_EN
    logic [DW-1:0] hyst;
`endif

    axis_level_trigger_if #(.DATA_WIDTH(DW)) s_if ();
    axis_level_trigger_if #(.DATA_WIDTH(DW)) m_if ();

    axis_level_trigger #(
        .DATA_WIDTH    (DW),
        .HOLDOFF_WIDTH (HW)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .arm     (arm),
        .slope   (slope),
        .level   (level),
        .holdoff (holdoff),
`ifdef AXIS_LEVEL_TRIGGER_HYST_EN
        .hyst    (hyst),
`endif
        .s_axis  (s_if),
        .m_axis  (m_if),
        .trigger (trigger),
        .armed   (armed)
    );

    always #5 aclk = ~aclk;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every transfer pops one expectation; trigger must mirror the expected tuser.
    always @(negedge aclk) begin
        if (aresetn === 1'b1) begin
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual data=0x%0h expected=none", m_if.tdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("tdata", 32'(m_if.tdata), 32'(e.data));
                    check("tstrb", 32'(m_if.tstrb), 32'(e.strb));
                    check("tlast", 32'(m_if.tlast), 32'(e.last));
                    check("tuser", 32'(m_if.tuser), 32'(e.user));
                    check("trigger_on_beat", 32'(trigger), 32'(e.user));
                    $display("beat data=%0d user=%0b trigger=%0b", $signed(m_if.tdata), m_if.tuser, trigger);
                end
            end else begin
                check("trigger_idle", 32'(trigger), 32'(0));
            end
        end
    end

    // Presents one beat starting just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input int data, input logic [2:0] strb, input logic last,
                             input logic exp_user, input int exp_armed);
        int   waited;
        logic ok;
        exp_t e;
        waited = 0;
        ok     = 1'b0;
        s_if.tdata  = DW'(data);
        s_if.tstrb  = strb;
        s_if.tlast  = last;
        s_if.tvalid = 1'b1;
        while (!ok && waited < 50) begin
            @(negedge aclk);
            if (s_if.tready) ok = 1'b1;
            else waited++;
        end
        if (!ok) begin
            check("accept_timeout", 32'(0), 32'(1));
            s_if.tvalid = 1'b0;
        end else begin
            if (exp_armed >= 0) check("armed_at_beat", 32'(armed), 32'(exp_armed));
            e.data = DW'(data);
            e.strb = strb;
            e.last = last;
            e.user = exp_user;
            exp_q.push_back(e);
            @(posedge aclk);
            #1;
            s_if.tvalid = 1'b0;
        end
    endtask

    task automatic rearm(input int lvl, input logic slp, input int hold);
        int waited;
        arm = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        level   = DW'(lvl);
        slope   = slp;
        holdoff = HW'(hold);
        arm     = 1'b1;
        waited  = 0;
        do begin
            @(negedge aclk);
            waited++;
        end while (!armed && waited < 20);
        if (!armed) check("arm_timeout", 32'(armed), 32'(1));
        @(posedge aclk);
        #1;
    endtask

    initial begin
        aresetn     = 1'b0;
        arm         = 1'b0;
        slope       = SLOPE_RISING;
        level       = '0;
        holdoff     = '0;
`ifdef AXIS_LEVEL_TRIGGER_HYST_EN
        hyst        = '0;
`endif
        s_if.tdata  = '0;
        s_if.tstrb  = '0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        m_if.tready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_tvalid", 32'(m_if.tvalid), 32'(0));
        check("rst_tdata", 32'(m_if.tdata), 32'(0));
        check("rst_tuser", 32'(m_if.tuser), 32'(0));
        check("rst_trigger", 32'(trigger), 32'(0));
        check("rst_armed", 32'(armed), 32'(0));
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // Rising ramp through level 100: only sample 100 is tagged.
        rearm(100, SLOPE_RISING, 0);
        send_beat(90,  3'b111, 1'b0, 1'b0, 1);
        send_beat(95,  3'b111, 1'b0, 1'b0, 1);
        send_beat(100, 3'b111, 1'b0, 1'b1, 1);
        send_beat(105, 3'b111, 1'b0, 1'b0, 0);
        send_beat(110, 3'b111, 1'b0, 1'b0, 1);
        send_beat(115, 3'b111, 1'b0, 1'b0, -1);
        send_beat(120, 3'b111, 1'b1, 1'b0, -1);

        // Falling through -5: equality counts, then a jump past the level.
        rearm(-5, SLOPE_FALLING, 0);
        send_beat(0,  3'b111, 1'b0, 1'b0, -1);
        send_beat(-4, 3'b111, 1'b0, 1'b0, -1);
        send_beat(-5, 3'b111, 1'b0, 1'b1, -1);
        send_beat(-6, 3'b111, 1'b0, 1'b0, -1);
        rearm(-5, SLOPE_FALLING, 0);
        send_beat(0,  3'b111, 1'b0, 1'b0, -1);
        send_beat(-6, 3'b111, 1'b0, 1'b1, -1);

        // Holdoff 3 with a crossing every 2 beats: triggers on beats 1, 7, 13.
        rearm(100, SLOPE_RISING, 3);
        for (int i = 0; i < 14; i++) begin
            automatic int  d  = (i % 2 == 1) ? 200 : 0;
            automatic logic u = (i == 1 || i == 7 || i == 13);
            automatic int  a  = ((i >= 2 && i <= 5) || (i >= 8 && i <= 11)) ? 0 : 1;
            send_beat(d, 3'b111, 1'b0, u, a);
        end

        // Back-pressure: crossing beat held five cycles, trigger only on release.
        rearm(100, SLOPE_RISING, 0);
        send_beat(50,  3'b101, 1'b0, 1'b0, -1);
        send_beat(150, 3'b010, 1'b1, 1'b1, -1);
        m_if.tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("bp_tdata_stable", 32'(m_if.tdata), 32'(150));
            check("bp_tvalid", 32'(m_if.tvalid), 32'(1));
            check("bp_trigger_low", 32'(trigger), 32'(0));
        end
        @(posedge aclk);
        #1;
        m_if.tready = 1'b1;
        @(posedge aclk);
        #1;

        // Disarmed crossing, then first armed beat above level.
        arm = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        send_beat(50,  3'b111, 1'b0, 1'b0, 0);
        send_beat(150, 3'b111, 1'b0, 1'b0, 0);
        send_beat(50,  3'b111, 1'b0, 1'b0, 0);
        rearm(100, SLOPE_RISING, 0);
        send_beat(200, 3'b111, 1'b0, 1'b0, 1);
        send_beat(250, 3'b111, 1'b0, 1'b0, 1);
        send_beat(50,  3'b111, 1'b0, 1'b0, 1);
        send_beat(150, 3'b111, 1'b0, 1'b1, 1);

`ifdef AXIS_LEVEL_TRIGGER_HYST_EN
        hyst = DW'(10);
        rearm(0, SLOPE_RISING, 0);
        send_beat(-5,  3'b111, 1'b0, 1'b0, -1);
        send_beat(5,   3'b111, 1'b0, 1'b0, -1);
        send_beat(-5,  3'b111, 1'b0, 1'b0, -1);
        send_beat(5,   3'b111, 1'b0, 1'b0, -1);
        send_beat(-11, 3'b111, 1'b0, 1'b0, -1);
        send_beat(5,   3'b111, 1'b0, 1'b1, -1);
`endif

        // Mid-stream reset discards the beat held in the output register.
        repeat (3) @(posedge aclk);
        #1;
        m_if.tready = 1'b0;
        send_beat(77, 3'b011, 1'b1, 1'b0, -1);
        @(negedge aclk);
        check("pre_rst_tvalid", 32'(m_if.tvalid), 32'(1));
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        check("mid_rst_tvalid", 32'(m_if.tvalid), 32'(0));
        check("mid_rst_tdata", 32'(m_if.tdata), 32'(0));
        check("mid_rst_tstrb", 32'(m_if.tstrb), 32'(0));
        check("mid_rst_tlast", 32'(m_if.tlast), 32'(0));
        check("mid_rst_tuser", 32'(m_if.tuser), 32'(0));
        check("mid_rst_armed", 32'(armed), 32'(0));
        check("mid_rst_trigger", 32'(trigger), 32'(0));
        exp_q.delete();
        m_if.tready = 1'b1;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        repeat (5) @(posedge aclk);
        @(negedge aclk);
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axis_level_trigger.md
# axis_level_trigger

Level/edge trigger stage upstream of the AXI-Stream recorder. It passes an AXI-Stream sample stream through a single register stage unchanged. It compares each signed sample against a programmable level and emits a one-cycle `trigger` pulse, aligned to the downstream acceptance of the crossing sample. The `m_axis_*` outputs and `trigger` connect directly to the recorder's `s_axis_*` and `trigger` inputs.

## Interface
Parameters:
- `DATA_WIDTH`, 24: sample width; samples are two's-complement signed.
- `HOLDOFF_WIDTH`, 16: width of the holdoff counter and of the `holdoff` input.

Ports:
- `aclk`, in, 1: the single clock.
- `aresetn`, in, 1: reset, synchronous and active-low.
- `arm`, in, 1: level-sensitive. 0 forces IDLE.
- `slope`, in, 1: edge select. 0 = rising, 1 = falling.
- `level`, in, DATA_WIDTH: signed trigger threshold.
- `holdoff`, in, HOLDOFF_WIDTH: number of input beats after a trigger during which no new trigger fires.
- `s_axis_tdata`, in, DATA_WIDTH: input sample.
- `s_axis_tstrb`, in, DATA_WIDTH/8: input byte qualifiers.
- `s_axis_tvalid`, in, 1: input valid.
- `s_axis_tlast`, in, 1: input end-of-packet marker.
- `s_axis_tready`, out, 1: input ready.
- `m_axis_tdata`, out, DATA_WIDTH: output sample.
- `m_axis_tstrb`, out, DATA_WIDTH/8: output byte qualifiers.
- `m_axis_tvalid`, out, 1: output valid.
- `m_axis_tlast`, out, 1: output end-of-packet marker.
- `m_axis_tuser`, out, 1: 1 on the crossing beat.
- `m_axis_tready`, in, 1: downstream ready.
- `trigger`, out, 1: one-cycle pulse. Equals `m_axis_tvalid & m_axis_tready & m_axis_tuser`.
- `armed`, out, 1: high in the ARMED state.

## Operation
- Datapath: one output register holding tdata, tstrb, tlast and tuser.
  - `s_axis_tready = !m_axis_tvalid | m_axis_tready` (combinational).
  - A beat is accepted when `s_axis_tvalid & s_axis_tready`.
- Previous-sample register `prev` with flag `prev_ok`.
  - `prev` is updated with every accepted beat.
  - `prev_ok` is cleared in IDLE and set by the first accepted beat in ARMED or HOLDOFF.
- Crossing condition, evaluated on the accepted beat `cur`, signed compare, only when `prev_ok` is set:
  - Rising: `prev < level` and `cur >= level`.
  - Falling: `prev > level` and `cur <= level`.
- States (typedef in the package):
  - IDLE: `arm=1` moves to ARMED on the next cycle.
  - ARMED: an accepted crossing beat sets its tuser, loads `cnt <= holdoff`, and moves to HOLDOFF.
  - HOLDOFF: each accepted beat with `cnt != 0` decrements `cnt`. With `cnt == 0` at the cycle edge, move to ARMED; crossings are not evaluated during HOLDOFF.
  - `arm=0` in any state moves to IDLE on the next cycle. Data keeps flowing in all states and no trigger fires outside ARMED.
- Boundary conditions:
  - `holdoff=0`: HOLDOFF lasts exactly one cycle with no beat requirement. The first crossing after that cycle can trigger.
  - A crossing on the same beat that `prev_ok` is first set never triggers.
  - `level`, `slope` and `holdoff` are sampled at the beat or load in use; no shadowing.
  - Full-scale values: compares are in signed DATA_WIDTH, with no overflow path.
- Back-pressure: the output register holds its contents while `m_axis_tvalid & !m_axis_tready`. tuser is attached to the beat, so `trigger` fires only on real transfer.

## Timing
- Latency: 1 cycle from input acceptance to `m_axis_tvalid`. Full throughput of 1 beat/cycle with continuous ready.
- Reset values:
  - `m_axis_tvalid=0`, `m_axis_tuser=0`, `m_axis_tlast=0`, `m_axis_tdata=0`, `m_axis_tstrb=0`.
  - `trigger=0`, `armed=0`, state IDLE, `prev_ok=0`, `cnt=0`.
- Reset mid-operation: the beat in flight is discarded (tvalid drops on the cycle after reset is sampled).
- `armed` is registered, derived from state.
- `trigger` is combinational from registered tuser/tvalid and the input `m_axis_tready`.

## Configuration
- Macro `AXIS_LEVEL_TRIGGER_HYST_EN`.
- Defined:
  - Adds input port `hyst` [DATA_WIDTH-1:0], unsigned.
  - Adds a `primed` flag, cleared on entering ARMED.
  - Rising: `primed` is set by a beat with `cur < level - hyst`. Falling: `primed` is set by a beat with `cur > level + hyst`.
  - In both cases, a crossing triggers only when `primed=1`.
  - Thresholds are computed in DATA_WIDTH+1 bits, so there is no wrap.
- Undefined: no `hyst` port, and a crossing triggers whenever the crossing condition holds.

## Structure
- Package `axis_trigger_pkg` holds:
  - the state enum `trig_state_t` (IDLE, ARMED, HOLDOFF);
  - the slope encoding constants `SLOPE_RISING=1'b0`, `SLOPE_FALLING=1'b1`.
- One sub-module, `axis_pipe_reg`: the generic single-stage valid/ready register carrying a packed payload of {tuser, tlast, tstrb, tdata}. The trigger FSM and compare stay in the top module.

## Test plan
- Rising: `level=100`, `slope=0`, `holdoff=0`, ramp 90,95,...,120 with ready held high → exactly one `trigger`, coincident with output beat 100, one cycle after its input acceptance.
- Falling: `level=-5`, `slope=1`, samples 0,-4,-5,-6 → trigger on -5. Samples 0,-6 → trigger on -6.
- Holdoff: `holdoff=3`, square wave crossing every 2 beats → triggers only on crossings at least 4 accepted beats apart. `armed` is low during the holdoff window.
- Back-pressure: crossing beat held for 5 cycles with `m_axis_tready=0` → tdata stable and `trigger` low throughout, then a single pulse on the release cycle. tlast/tstrb pass through bit-exact.
- Arm and reset: `arm=0` during a crossing → no trigger. The first beat after `arm` rises is 200 with `level=100` → no trigger. `aresetn` low mid-stream → all outputs reach reset values on the next edge.
- With `AXIS_LEVEL_TRIGGER_HYST_EN`: `level=0`, `hyst=10`, samples -5,5,-5,5 → no trigger. Samples -11,5 → trigger on 5.
